// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int LANE_W = 8;

  function automatic int lane_count(input int width);
    return width / LANE_W;
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational lane merge: enabled lanes come from new_word, the rest from old_word.
module ram_byte_merge
  import ram_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]             old_word,
  input  logic [WIDTH-1:0]             new_word,
  input  logic [lane_count(WIDTH)-1:0] lane_en,
  output logic [WIDTH-1:0]             merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < lane_count(WIDTH); i++) begin
      if (lane_en[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/ram_dp_bytewr.sv
// Simple-dual-port RAM with byte lane writes, registered read, write-first bypass,
// range error pulse and a self-timed clear sweep instead of a flop reset of the array.
module ram_dp_bytewr
  import ram_pkg::*;
#(
  parameter int              ADDRESS   = 3,
  parameter int              DEPTH     = 8,
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WrEn,
  input  logic [ADDRESS-1:0]           WrAddr,
  input  logic [WIDTH-1:0]             WrData,
  input  logic [lane_count(WIDTH)-1:0] WrByteEn,
  input  logic                         RdEn,
  input  logic [ADDRESS-1:0]           RdAddr,
  output logic [WIDTH-1:0]             RdData,
  output logic                         RdValid,
  input  logic                         ClrReq,
  output logic                         Busy,
  output logic                         AddrErr
);

  localparam logic [ADDRESS:0]   DEPTH_W = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS-1:0] LAST    = ADDRESS'(DEPTH-1);

  ram_state_t         state, state_nxt;
  logic [ADDRESS-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   wr_merged;
  logic               ready_op, wr_oor, rd_oor, wr_do, rd_do, bypass;

  // A clear request in READY swallows any access issued in the same cycle.
  assign ready_op = (state == READY) && !ClrReq;
  assign wr_oor   = {1'b0, WrAddr} >= DEPTH_W;
  assign rd_oor   = {1'b0, RdAddr} >= DEPTH_W;
  assign wr_do    = ready_op && WrEn && !wr_oor;
  assign rd_do    = ready_op && RdEn;
  assign bypass   = wr_do && (WrAddr == RdAddr);
  assign Busy     = (state == INIT);

  ram_byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_word (mem[WrAddr]),
    .new_word (WrData),
    .lane_en  (WrByteEn),
    .merged   (wr_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      READY: begin
        if (ClrReq) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Array has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= CLR_VALUE;
    else if (wr_do)    mem[WrAddr] <= wr_merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RdData  <= '0;
      RdValid <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      RdValid <= rd_do;
      AddrErr <= ready_op && ((WrEn && wr_oor) || (RdEn && rd_oor));
      if (rd_do) begin
        if (rd_oor)      RdData <= CLR_VALUE;
        else if (bypass) RdData <= wr_merged;
        else             RdData <= mem[RdAddr];
      end
    end
  end

endmodule
